// File: rtl/el2_lsu_idle_ctl.sv
// LSU quiescence controller: idle detection with hysteresis, TLU halt
// drain/acknowledge handshake, and a saturating gated-clock cycle counter.
module el2_lsu_idle_ctl #(
    parameter int IDLE_HYST = 4,
    parameter int EVT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lsu_free_c2_clken,
    input  logic             dma_dccm_req,
    input  logic             lsu_bus_buffer_empty_any,
    input  logic             lsu_stbuf_empty_any,
    input  logic             halt_req,
    input  logic             cnt_clr,
    output logic             halt_ack,
    output logic             lsu_idle,
    output logic             wake,
    output logic [EVT_W-1:0] gated_cnt
);

    typedef enum logic [1:0] {
        ACTIVE,
        DRAIN,
        IDLE,
        HALTED
    } state_t;

    localparam logic [7:0] HYST_M1 = 8'(IDLE_HYST - 1);

    state_t     state;
    state_t     nxt;
    logic [7:0] q;
    logic       busy;
    logic       hyst_met;

    assign busy = lsu_free_c2_clken | dma_dccm_req |
                  ~lsu_bus_buffer_empty_any | ~lsu_stbuf_empty_any;

    assign hyst_met = ~busy & (q == HYST_M1);

    // A dropped halt request always wins: never acknowledge a halt nobody asked for.
    always_comb begin
        nxt = state;
        unique case (state)
            ACTIVE: begin
                if (halt_req)      nxt = DRAIN;
                else if (hyst_met) nxt = IDLE;
            end
            DRAIN: begin
                if (!halt_req)     nxt = ACTIVE;
                else if (hyst_met) nxt = HALTED;
            end
            IDLE: begin
                if (busy)          nxt = halt_req ? DRAIN : ACTIVE;
                else if (halt_req) nxt = HALTED;
            end
            HALTED: begin
                if (!halt_req)     nxt = ACTIVE;
                else if (busy)     nxt = DRAIN;
            end
            default:               nxt = ACTIVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACTIVE;
            q        <= 8'd0;
            halt_ack <= 1'b0;
            lsu_idle <= 1'b0;
            wake     <= 1'b0;
        end else begin
            state    <= nxt;
            q        <= (busy || (nxt != state)) ? 8'd0 : q + 8'd1;
            halt_ack <= (nxt == HALTED);
            lsu_idle <= (nxt == IDLE);
            wake     <= (state == IDLE) && ((nxt == ACTIVE) || (nxt == DRAIN));
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            gated_cnt <= '0;
        end else if (!lsu_free_c2_clken && !(&gated_cnt)) begin
            gated_cnt <= gated_cnt + EVT_W'(1);
        end
    end

endmodule

// File: tb/tb_el2_lsu_idle_ctl.sv
// Bench for el2_lsu_idle_ctl: directed timeline checks plus randomized
// traffic against a behavioural model, on IDLE_HYST=4 and IDLE_HYST=1 copies.
module tb_el2_lsu_idle_ctl;

    localparam int M_ACT  = 0;
    localparam int M_DRN  = 1;
    localparam int M_IDL  = 2;
    localparam int M_HLT  = 3;
    localparam int CNT_MX = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst      = 1'b1;
    logic clken    = 1'b0;
    logic dma      = 1'b0;
    logic bus_e    = 1'b1;
    logic stb_e    = 1'b1;
    logic halt_req = 1'b0;
    logic cnt_clr  = 1'b0;

    logic       ack_w  [2];
    logic       idle_w [2];
    logic       wake_w [2];
    logic [3:0] cnt_w  [2];

    el2_lsu_idle_ctl #(.IDLE_HYST(4), .EVT_W(4)) u_h4 (
        .clk                      (clk),
        .rst                      (rst),
        .lsu_free_c2_clken        (clken),
        .dma_dccm_req             (dma),
        .lsu_bus_buffer_empty_any (bus_e),
        .lsu_stbuf_empty_any      (stb_e),
        .halt_req                 (halt_req),
        .cnt_clr                  (cnt_clr),
        .halt_ack                 (ack_w[0]),
        .lsu_idle                 (idle_w[0]),
        .wake                     (wake_w[0]),
        .gated_cnt                (cnt_w[0])
    );

    el2_lsu_idle_ctl #(.IDLE_HYST(1), .EVT_W(4)) u_h1 (
        .clk                      (clk),
        .rst                      (rst),
        .lsu_free_c2_clken        (clken),
        .dma_dccm_req             (dma),
        .lsu_bus_buffer_empty_any (bus_e),
        .lsu_stbuf_empty_any      (stb_e),
        .halt_req                 (halt_req),
        .cnt_clr                  (cnt_clr),
        .halt_ack                 (ack_w[1]),
        .lsu_idle                 (idle_w[1]),
        .wake                     (wake_w[1]),
        .gated_cnt                (cnt_w[1])
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int m_mode [2];
    int m_run  [2];
    bit m_ack  [2];
    bit m_idle [2];
    bit m_wake [2];
    int m_cnt;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int hyst_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // Reference: modes plus a count of consecutive quiet cycles spent in the mode.
    task automatic model_tick();
        bit busy;
        int qlen;
        int nm;
        busy = clken | dma | !bus_e | !stb_e;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_mode[i] = M_ACT;
                m_run[i]  = 0;
                m_ack[i]  = 1'b0;
                m_idle[i] = 1'b0;
                m_wake[i] = 1'b0;
            end else begin
                qlen = busy ? 0 : m_run[i] + 1;
                if (qlen > 1000) qlen = 1000;
                nm = m_mode[i];
                case (m_mode[i])
                    M_ACT: nm = halt_req ? M_DRN :
                                (qlen >= hyst_of(i)) ? M_IDL : M_ACT;
                    M_DRN: nm = !halt_req ? M_ACT :
                                (qlen >= hyst_of(i)) ? M_HLT : M_DRN;
                    M_IDL: nm = busy ? (halt_req ? M_DRN : M_ACT) :
                                halt_req ? M_HLT : M_IDL;
                    default: nm = !halt_req ? M_ACT : busy ? M_DRN : M_HLT;
                endcase
                m_wake[i] = (m_mode[i] == M_IDL) && busy;
                m_run[i]  = (nm != m_mode[i]) ? 0 : qlen;
                m_mode[i] = nm;
                m_ack[i]  = (nm == M_HLT);
                m_idle[i] = (nm == M_IDL);
            end
        end
        if (rst || cnt_clr)                 m_cnt = 0;
        else if (!clken && m_cnt < CNT_MX)  m_cnt = m_cnt + 1;
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        cyc++;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ack%0d", i),  32'(ack_w[i]),  32'(m_ack[i]));
            chk($sformatf("idle%0d", i), 32'(idle_w[i]), 32'(m_idle[i]));
            chk($sformatf("wake%0d", i), 32'(wake_w[i]), 32'(m_wake[i]));
            chk($sformatf("cnt%0d", i),  32'(cnt_w[i]),  32'(m_cnt));
        end
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        cyc = 0;
        rst = 1'b0;
    endtask

    initial begin
        int  plen;
        bit  quiet;
        plen  = 0;
        quiet = 1'b1;

        // Idle entry, wake pulse, gated counter saturation and clear
        do_reset();
        chk("rst_ack",  32'(ack_w[0]),  32'd0);
        chk("rst_idle", 32'(idle_w[0]), 32'd0);
        chk("rst_wake", 32'(wake_w[0]), 32'd0);
        chk("rst_cnt",  32'(cnt_w[0]),  32'd0);
        run_to(3);  chk("idle_c3", 32'(idle_w[0]), 32'd0);
        run_to(4);  chk("idle_c4", 32'(idle_w[0]), 32'd1);
        chk("cnt_c4", 32'(cnt_w[0]), 32'd4);
        run_to(10); dma = 1'b1;
        step();     dma = 1'b0;
        chk("exit_idle", 32'(idle_w[0]), 32'd0);
        chk("wake_c11",  32'(wake_w[0]), 32'd1);
        step();     chk("wake_c12", 32'(wake_w[0]), 32'd0);
        run_to(14); chk("idle_c14", 32'(idle_w[0]), 32'd0);
        run_to(15); chk("idle_c15", 32'(idle_w[0]), 32'd1);
        chk("cnt_c15", 32'(cnt_w[0]), 32'd15);
        run_to(20); chk("cnt_sat", 32'(cnt_w[0]), 32'd15);
        cnt_clr = 1'b1;
        step();     cnt_clr = 1'b0;
        chk("cnt_clr", 32'(cnt_w[0]), 32'd0);
        step();     chk("cnt_inc", 32'(cnt_w[0]), 32'd1);

        // Halt drain from ACTIVE, release, re-halt, busy during halt, reset in drain
        do_reset();
        stb_e = 1'b0;
        run_to(5);  halt_req = 1'b1;
        run_to(20); stb_e = 1'b1;
        run_to(23); chk("ack_c23", 32'(ack_w[0]), 32'd0);
        run_to(24); chk("ack_c24", 32'(ack_w[0]), 32'd1);
        run_to(30); halt_req = 1'b0;
        step();     chk("rel_c31", 32'(ack_w[0]), 32'd0);
        run_to(32); halt_req = 1'b1;
        run_to(37); chk("ack_c37", 32'(ack_w[0]), 32'd1);
        run_to(40); bus_e = 1'b0;
        step();     bus_e = 1'b1;
        chk("ack_drop", 32'(ack_w[0]), 32'd0);
        run_to(44); chk("ack_c44", 32'(ack_w[0]), 32'd0);
        run_to(45); chk("ack_c45", 32'(ack_w[0]), 32'd1);
        run_to(46); halt_req = 1'b0;
        step();     chk("rel_c47", 32'(ack_w[0]), 32'd0);
        run_to(48); halt_req = 1'b1;
        run_to(51); rst = 1'b1;
        step();     rst = 1'b0; halt_req = 1'b0;
        chk("mid_rst_ack",  32'(ack_w[0]),  32'd0);
        chk("mid_rst_idle", 32'(idle_w[0]), 32'd0);
        chk("mid_rst_wake", 32'(wake_w[0]), 32'd0);
        chk("mid_rst_cnt",  32'(cnt_w[0]),  32'd0);
        run_to(55); chk("idle_c55", 32'(idle_w[0]), 32'd0);
        run_to(56); chk("idle_c56", 32'(idle_w[0]), 32'd1);

        // Randomized traffic in quiet/busy bursts with a protocol-abiding TLU
        repeat (3000) begin
            if (plen == 0) begin
                quiet = !quiet;
                plen  = $urandom_range(2, 14);
            end
            plen--;
            clken   = !quiet && ($urandom % 3 == 0);
            dma     = !quiet && ($urandom % 3 == 0);
            bus_e   = quiet || ($urandom % 3 != 0);
            stb_e   = quiet || ($urandom % 3 != 0);
            cnt_clr = ($urandom % 32 == 0);
            rst     = ($urandom % 400 == 0);
            if (rst)
                halt_req = 1'b0;
            else if (!halt_req)
                halt_req = ($urandom % 30 == 0);
            else if (m_ack[0] && m_ack[1] && ($urandom % 3 == 0))
                halt_req = 1'b0;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/el2_lsu_idle_ctl.md
# el2_lsu_idle_ctl

LSU quiescence controller: the consumer of the LSU clock-enable and drain indications. It decides when the LSU is idle and answers TLU halt requests with a drain-then-acknowledge handshake. It also keeps a saturating count of cycles in which the LSU free clock was gated. It sits beside the LSU clock-domain logic inside the LSU and reports to the TLU.

## Interface
Parameters:
- IDLE_HYST, 4: consecutive quiet cycles required before idle or halt-ack; legal range 1..255.
- EVT_W, 16: width of the gated-cycle counter.

Ports:
- clk  in  1  core clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- lsu_free_c2_clken  in  1  LSU free-clock enable; 1 = LSU activity.
- dma_dccm_req  in  1  DMA access to DCCM pending.
- lsu_bus_buffer_empty_any  in  1  external bus buffer empty.
- lsu_stbuf_empty_any  in  1  store buffer empty.
- halt_req  in  1  TLU request to quiesce the LSU; level, held until it sees halt_ack.
- cnt_clr  in  1  clear gated_cnt.
- halt_ack  out  1  LSU drained and halted; level.
- lsu_idle  out  1  LSU idle (hysteresis met, no halt in progress).
- wake  out  1  one-cycle pulse when activity leaves IDLE.
- gated_cnt  out  EVT_W  cycles with lsu_free_c2_clken=0; saturating.

## Operation
- busy = lsu_free_c2_clken | dma_dccm_req | ~lsu_bus_buffer_empty_any | ~lsu_stbuf_empty_any.
- Quiet counter q, 8 bits:
  - Cleared whenever busy and on every state change.
  - Otherwise incremented.
  - "Hysteresis met" means ~busy & q == IDLE_HYST-1.
- FSM states: ACTIVE, DRAIN, IDLE, HALTED. Reset state is ACTIVE.
- ACTIVE:
  - halt_req → DRAIN. halt_req has priority over hysteresis met.
  - Otherwise, hysteresis met → IDLE.
- DRAIN:
  - Hysteresis met → HALTED.
  - halt_req dropped → ACTIVE.
- IDLE:
  - busy → ACTIVE and pulse wake. If halt_req is also high, go to DRAIN instead, still pulsing wake.
  - halt_req & ~busy → HALTED directly.
- HALTED:
  - halt_req dropped → ACTIVE. This has priority over busy.
  - busy with halt_req still high (e.g. a DMA during halt) → DRAIN; halt_ack drops.
- Outputs are registered and decoded from the state:
  - halt_ack = (state == HALTED).
  - lsu_idle = (state == IDLE).
  - wake is registered from the IDLE→ACTIVE or IDLE→DRAIN transition.
- gated_cnt:
  - cnt_clr → 0. This has priority; no increment in that cycle.
  - Else, if ~lsu_free_c2_clken and gated_cnt is not all-ones → +1.
  - Holds at all-ones (saturation, no wrap).
  - Independent of the FSM state.
- Reset (rst=1 at a clk edge): state=ACTIVE, q=0, halt_ack=0, lsu_idle=0, wake=0, gated_cnt=0. Reset mid-handshake abandons the drain; TLU re-requests.

## Timing
- Idle entry: quiet cycles c1..cIDLE_HYST. lsu_idle=1 in cycle cIDLE_HYST+1.
  - IDLE_HYST=1: lsu_idle one cycle after the first quiet cycle.
- Idle exit: busy in cycle n → lsu_idle=0 and wake=1 in cycle n+1; wake=0 in n+2.
- Halt from ACTIVE with LSU already quiet:
  - halt_req rises in cycle n → DRAIN in n+1.
  - q counts from n+1 → halt_ack=1 in n+1+IDLE_HYST.
- Halt from IDLE (quiet): halt_ack=1 one cycle after halt_req rises.
- Release: halt_req falls in cycle n → halt_ack=0 in n+1.
- A busy cycle in DRAIN restarts the full IDLE_HYST count.
- gated_cnt reflects the sampled input one cycle later.

## Test plan
- IDLE_HYST=4, all inputs quiet from reset release at cycle 0 → lsu_idle=1 at cycle 4. gated_cnt=4 at cycle 4.
- From IDLE, pulse dma_dccm_req for 1 cycle at cycle 10 → lsu_idle=0 and wake=1 at cycle 11. wake=0 at 12. lsu_idle=1 again at cycle 15.
- ACTIVE with lsu_stbuf_empty_any=0 until cycle 20, halt_req=1 from cycle 5 → DRAIN at 6; stbuf quiet from 20; halt_ack=1 at cycle 24. halt_req=0 at 30 → halt_ack=0 at 31.
- HALTED, then lsu_bus_buffer_empty_any=0 for one cycle with halt_req high → halt_ack drops the next cycle; it reasserts IDLE_HYST cycles after the buffer is empty again.
- EVT_W=4, lsu_free_c2_clken=0 for 20 cycles → gated_cnt saturates at 15 and holds. cnt_clr together with a gated cycle → gated_cnt=0, then increments next cycle.
- Assert rst for one cycle while in DRAIN with q=2 → next cycle: state ACTIVE, all outputs 0, gated_cnt=0. Idle re-entry takes a full 4 quiet cycles.
